// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   state_e    : sequencer state (INIT flushes the pipe, RUN is normal flow,
//                MISS means the data memory is stalling the MEM stage)
//   REG_ADDR_W : register-file address width
//   X0         : address of the hard-wired zero register
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter.
//   clk_i : clock
//   clr_i : synchronous clear, active-high
//   inc_i : add one this cycle (ignored once the count is all-ones)
//   cnt_o : current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core. Each cycle it decides whether the
// PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold, flush or
// take a bubble, handling load-use hazards, taken branches resolved in ID and
// data-memory busy stalls. Also keeps saturating performance counters and a
// sticky watchdog for a memory that never completes.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i       : source registers of the ID instruction
//   id_use_rs1_i/_rs2_i     : ID instruction actually reads that source
//   ex_rd_i, ex_memread_i   : destination / is-load of the EX instruction
//   branch_taken_i          : ID branch resolved taken
//   mem_busy_i              : MEM-stage access cannot complete this cycle
//   pc_write_o .. memwb_bubble_o : per-stage pipeline controls (combinational)
//   lu_stall_cnt_o, flush_cnt_o, miss_cyc_cnt_o : saturating counters
//   err_o                   : sticky stuck-memory error
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024,
    parameter int INIT_CYCLES  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_memread_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  idex_hold_o,
    output logic                  exmem_hold_o,
    output logic                  memwb_bubble_o,
    output logic [CNT_W-1:0]      lu_stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      miss_cyc_cnt_o,
    output logic                  err_o
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int RUN_W  = $clog2(MISS_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [RUN_W-1:0]    busy_run_q, busy_run_d;
    logic                err_q, err_d;
    logic                lu_hazard;
    logic                lu_inc, flush_inc, miss_inc;

    // x0 never carries a value, so a load targeting it cannot create a hazard.
    assign lu_hazard = ex_memread_i && (ex_rd_i != X0) &&
                       ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                        (id_use_rs2_i && (ex_rd_i == id_rs2_i)));

    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        idex_hold_o    = 1'b0;
        exmem_hold_o   = 1'b0;
        memwb_bubble_o = 1'b0;
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        busy_run_d     = busy_run_q;
        err_d          = err_q;
        lu_inc         = 1'b0;
        flush_inc      = 1'b0;
        miss_inc       = 1'b0;

        case (state_q)
            INIT: begin
                // Fill every stage with NOPs; all hazard inputs are ignored.
                pc_write_o     = 1'b0;
                ifid_flush_o   = 1'b1;
                idex_bubble_o  = 1'b1;
                memwb_bubble_o = 1'b1;
                busy_run_d     = '0;
                if (init_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q - INIT_W'(1);
                end
            end
            default: begin
                if (mem_busy_i) begin
                    // Freeze everything upstream of MEM; WB retires nothing.
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    idex_hold_o    = 1'b1;
                    exmem_hold_o   = 1'b1;
                    memwb_bubble_o = 1'b1;
                    miss_inc       = 1'b1;
                    state_d        = MISS;
                    if (busy_run_q != RUN_W'(MISS_TIMEOUT)) begin
                        busy_run_d = busy_run_q + RUN_W'(1);
                    end
                    if (busy_run_q >= RUN_W'(MISS_TIMEOUT - 1)) begin
                        err_d = 1'b1;
                    end
                end else begin
                    busy_run_d = '0;
                    state_d    = RUN;
                    if (lu_hazard) begin
                        // A branch seen now used stale operands; it is
                        // re-evaluated next cycle, so no flush here.
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_bubble_o = 1'b1;
                        lu_inc        = 1'b1;
                    end else if (branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        flush_inc    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            init_cnt_q <= INIT_W'(INIT_CYCLES - 1);
            busy_run_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            busy_run_q <= busy_run_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (lu_inc),
        .cnt_o (lu_stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (miss_inc),
        .cnt_o (miss_cyc_cnt_o)
    );

endmodule
